tpi_sync: RTL and testbench
===========================

Name: tpi_sync

Overview:
- Parametrised, fully synchronous successor to the current 6523 TPI emulation used on the TCBM bridge.
- Provides three ports of configurable width, each with a data register (PR) and a data-direction register (DDR).
- Adds a 6525-style mode-control extension: edge-latched interrupt inputs, a masked /IRQ output, and a CA/CB (DAV/ACK) handshake engine with pulse and interlocked modes plus an ACK timeout.
- Sits between the PLA/chip-select decode and the pin tristate buffers. The top level owns the tristates.

Parameters:
PA_W, 8, port A width (1..8)
PB_W, 2, port B width (1..8)
PC_W, 2, port C width (1..8); mode control is only available when PC_W=8
SYNC_STAGES, 2, input synchroniser depth for all pin and cs_n inputs (>=2)
PULSE_LEN, 4, CA low time in pulse mode, in clock cycles (>=1)
ACK_TIMEOUT, 0, handshake timeout in cycles; 0 disables the timeout

Ports:
clock  in  1  system clock; the only clock
_reset  in  1  synchronous reset, active-low
cs_n  in  1  chip select from PLA decode, asynchronous to clock
we_n  in  1  0 = write, 1 = read; sampled at the access edge
rs  in  3  register select; sampled at the access edge
din  in  8  write data
dout  out  8  read data
dout_oe  out  1  read data valid/drive enable
pa_i/pa_o/pa_oe  in/out/out  PA_W  port A pins split into input, output and output-enable
pb_i/pb_o/pb_oe  in/out/out  PB_W  port B pins
pc_i/pc_o/pc_oe  in/out/out  PC_W  port C pins
irq_n  out  1  interrupt request, active-low

Behaviour:
- Reset (_reset low at a clock edge): all registers, flags and outputs go to 0, except irq_n=1 and CA (pc_o[6])=1. The FSM enters IDLE. Reset overrides any access in progress.
- Access edge: the falling edge of the synchronised cs_n. Exactly one access is performed per cs_n assertion.
- Writes take effect on the clock edge after detection.
- Reads:
  - dout is registered one cycle after detection and held until cs_n is seen high.
  - dout_oe = 1 over the same window, for reads only.
- Register map:
  - 0/1/2 = PRA/PRB/PRC.
  - 3/4/5 = DDRA/DDRB/DDRC.
  - 6: write = IMR[6:0]; read = ILR[6:0].
  - 7 = CR.
- Port register reads: returned bit = DDR ? PR : synchronised pin.
- Bits above a port's width read as 0. Writes to those bits are ignored.
- Pin outputs: px_o = PR, px_oe = DDR.
- CR bits:
  - [0] MC (forced to 0 when PC_W!=8).
  - [1] IEDGE: 0 = falling edge, 1 = rising edge.
  - [3:2] CA_MODE: 00 = CA low, 01 = CA high, 10 = pulse, 11 = interlocked.
  - [7:4] read as 0.
- When MC=1, the upper port C bits are overridden:
  - pc6 = CA output: oe forced 1.
  - pc7 = CB input: oe forced 0.
  - pc5 = irq_n mirror: oe forced 1.
  - pc[4:0] follow DDRC.
- ILR flags (MC=1 only):
  - Bits 0..4: set on the selected edge of the synchronised pc[4:0].
  - Bit 5: set on the CB edge (same IEDGE polarity).
  - Bit 6: set on handshake timeout.
- ILR read clears the flags captured in the read data. A flag set in the same cycle as the clear stays set.
- irq_n = !(MC & |(ILR & IMR)), registered.
- Handshake FSM (MC=1, CA_MODE=1x). States:
  - IDLE: CA=1.
  - PULSE: CA=0, counter counts to PULSE_LEN, then IDLE.
  - WAIT_ACK: CA=0, leaves on CB edge to IDLE, or on timeout to IDLE with ILR6 set.
- Trigger: any write to PRA. Mode 10 enters PULSE; mode 11 enters WAIT_ACK.
- A PRA write while in PULSE restarts the count. A PRA write while in WAIT_ACK keeps waiting and restarts the timeout.
- A CB edge in the same cycle as a PRA write: the write wins, state is WAIT_ACK.
- Clearing MC or changing CA_MODE returns the FSM to IDLE on the next cycle.

Decomposition:
- Package tpi_pkg holds:
  - register address constants,
  - CR bit positions,
  - CA_MODE encodings,
  - handshake state typedef (IDLE, PULSE, WAIT_ACK).
- Sub-module tpi_port #(W, SYNC_STAGES): PR and DDR registers, input synchroniser, readback mux. Instantiated three times.

Test Plan:
- Reset, then write DDRA=0xF0 and PRA=0xA5 with pa_i=0x3C. Expect pa_oe=0xF0, pa_o=0xA5, PRA read=0xAC, dout_oe high one cycle after the access edge.
- PB_W=2: write PRB=0xFF, DDRB=0xFF, read PRB -> 0x03; bits 7:2 read as 0.
- MC=1, IEDGE=0, IMR=0x01: pc_i[0] 1->0 -> ILR=0x01, irq_n low within SYNC_STAGES+2 cycles. Read reg 6 returns 0x01, then irq_n=1 and ILR=0.
- CA_MODE=10, PULSE_LEN=4: write PRA -> pc_o[6] low for exactly 4 cycles, then high. A second write at count 2 extends the low to 6 cycles total.
- CA_MODE=11, ACK_TIMEOUT=16: write PRA -> CA low.
  - CB edge at cycle 5 -> CA high, ILR5 set.
  - With no CB edge -> CA high at cycle 16, ILR6 set.
- Assert _reset while in WAIT_ACK with cs_n low -> next edge: CA=1, dout_oe=0, irq_n=1, all registers 0.

Source files
------------

// File: rtl/tpi_pkg.sv
// Shared constants for the TPI: register map, CR bit positions, CA modes and handshake states.
package tpi_pkg;

    localparam logic [2:0] REG_PRA     = 3'd0;
    localparam logic [2:0] REG_PRB     = 3'd1;
    localparam logic [2:0] REG_PRC     = 3'd2;
    localparam logic [2:0] REG_DDRA    = 3'd3;
    localparam logic [2:0] REG_DDRB    = 3'd4;
    localparam logic [2:0] REG_DDRC    = 3'd5;
    localparam logic [2:0] REG_IMR_ILR = 3'd6;
    localparam logic [2:0] REG_CR      = 3'd7;

    localparam int CR_MC      = 0;
    localparam int CR_IEDGE   = 1;
    localparam int CR_MODE_LO = 2;
    localparam int CR_MODE_HI = 3;

    localparam logic [1:0] CA_LOW   = 2'b00;
    localparam logic [1:0] CA_HIGH  = 2'b01;
    localparam logic [1:0] CA_PULSE = 2'b10;
    localparam logic [1:0] CA_ILOCK = 2'b11;

    typedef logic [1:0] hs_state_t;
    localparam hs_state_t HS_IDLE     = 2'd0;
    localparam hs_state_t HS_PULSE    = 2'd1;
    localparam hs_state_t HS_WAIT_ACK = 2'd2;

endpackage

// File: rtl/tpi_port.sv
// One TPI port: PR/DDR registers, pin synchroniser and readback (DDR ? PR : pin).
// Registers update on the write strobe edge; pin samples lag by SYNC_STAGES cycles; no backpressure.
module tpi_port
    import tpi_pkg::*;
#(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_wr_pr,
    input  logic         i_wr_ddr,
    input  logic [W-1:0] i_wdat,
    input  logic [W-1:0] i_pin,
    output logic [W-1:0] o_pr,
    output logic [W-1:0] o_ddr,
    output logic [W-1:0] o_pin_s,
    output logic [W-1:0] o_rdat
);

    logic [W-1:0]                  r_pr;
    logic [W-1:0]                  r_ddr;
    logic [SYNC_STAGES-1:0][W-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pr   <= '0;
            r_ddr  <= '0;
            r_sync <= '0;
        end else begin
            if (i_wr_pr)  r_pr  <= i_wdat;
            if (i_wr_ddr) r_ddr <= i_wdat;
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    assign o_pr    = r_pr;
    assign o_ddr   = r_ddr;
    assign o_pin_s = r_sync[SYNC_STAGES-1];
    assign o_rdat  = (r_ddr & r_pr) | (~r_ddr & r_sync[SYNC_STAGES-1]);

endmodule

// File: rtl/tpi_sync.sv
// Synchronous 6523/6525-style TPI: three ports, edge-latched interrupts and a CA/CB handshake.
// Access acts one cycle after the synchronised cs_n falling edge; read data held until cs_n seen high.
module tpi_sync
    import tpi_pkg::*;
#(
    parameter int PA_W        = 8,
    parameter int PB_W        = 2,
    parameter int PC_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 4,
    parameter int ACK_TIMEOUT = 0
) (
    input  logic            clock,
    input  logic            _reset,
    input  logic            cs_n,
    input  logic            we_n,
    input  logic [2:0]      rs,
    input  logic [7:0]      din,
    output logic [7:0]      dout,
    output logic            dout_oe,
    input  logic [PA_W-1:0] pa_i,
    output logic [PA_W-1:0] pa_o,
    output logic [PA_W-1:0] pa_oe,
    input  logic [PB_W-1:0] pb_i,
    output logic [PB_W-1:0] pb_o,
    output logic [PB_W-1:0] pb_oe,
    input  logic [PC_W-1:0] pc_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_oe,
    output logic            irq_n
);

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_cs_d;
    logic [7:0]             r_dout;
    logic                   r_dout_oe;
    logic [6:0]             r_imr;
    logic [6:0]             r_ilr;
    logic [3:0]             r_cr;
    logic                   r_irq_n;
    logic [7:0]             r_pc_prev;
    hs_state_t              r_state;
    logic [15:0]            r_cnt;

    logic w_cs_s, w_access, w_wr, w_rd, w_pra_wr, w_cr_wr;
    logic w_mc, w_hs_on, w_mode_chg, w_cb_edge, w_timeout, w_ca;
    logic [1:0]      w_mode;
    logic [7:0]      w_rdata, w_pc_s8, w_pc_edge;
    logic [6:0]      w_ilr_set, w_ilr_clr;
    logic [PA_W-1:0] w_pa_rd, w_pa_pin;
    logic [PB_W-1:0] w_pb_rd, w_pb_pin;
    logic [PC_W-1:0] w_pc_rd, w_pc_s, w_prc, w_ddrc;
    hs_state_t       w_state_nx;
    logic [15:0]     w_cnt_nx;

    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_access = r_cs_d & ~w_cs_s;
    assign w_wr     = w_access & ~we_n;
    assign w_rd     = w_access & we_n;
    assign w_pra_wr = w_wr && (rs == REG_PRA);
    assign w_cr_wr  = w_wr && (rs == REG_CR);

    tpi_port #(.W(PA_W), .SYNC_STAGES(SYNC_STAGES)) u_pa (
        .i_clk(clock), .i_rst_n(_reset),
        .i_wr_pr(w_pra_wr), .i_wr_ddr(w_wr && (rs == REG_DDRA)),
        .i_wdat(din[PA_W-1:0]), .i_pin(pa_i),
        .o_pr(pa_o), .o_ddr(pa_oe), .o_pin_s(w_pa_pin), .o_rdat(w_pa_rd)
    );

    tpi_port #(.W(PB_W), .SYNC_STAGES(SYNC_STAGES)) u_pb (
        .i_clk(clock), .i_rst_n(_reset),
        .i_wr_pr(w_wr && (rs == REG_PRB)), .i_wr_ddr(w_wr && (rs == REG_DDRB)),
        .i_wdat(din[PB_W-1:0]), .i_pin(pb_i),
        .o_pr(pb_o), .o_ddr(pb_oe), .o_pin_s(w_pb_pin), .o_rdat(w_pb_rd)
    );

    tpi_port #(.W(PC_W), .SYNC_STAGES(SYNC_STAGES)) u_pc (
        .i_clk(clock), .i_rst_n(_reset),
        .i_wr_pr(w_wr && (rs == REG_PRC)), .i_wr_ddr(w_wr && (rs == REG_DDRC)),
        .i_wdat(din[PC_W-1:0]), .i_pin(pc_i),
        .o_pr(w_prc), .o_ddr(w_ddrc), .o_pin_s(w_pc_s), .o_rdat(w_pc_rd)
    );

    // Only port C's synchronised pins feed edge detection; bits 6:5 carry no flag.
    logic w_unused;
    assign w_unused = ^{w_pa_pin, w_pb_pin, w_pc_edge[6:5]};

    always_comb begin
        w_pc_s8            = '0;
        w_pc_s8[PC_W-1:0]  = w_pc_s;
    end

    assign w_mc       = r_cr[CR_MC];
    assign w_mode     = r_cr[CR_MODE_HI:CR_MODE_LO];
    assign w_hs_on    = w_mc & w_mode[1];
    assign w_pc_edge  = r_cr[CR_IEDGE] ? (~r_pc_prev & w_pc_s8) : (r_pc_prev & ~w_pc_s8);
    assign w_cb_edge  = w_mc & w_pc_edge[7];
    assign w_mode_chg = w_cr_wr && ((din[CR_MODE_HI:CR_MODE_LO] != w_mode) || !din[CR_MC]);
    assign w_timeout  = (r_state == HS_WAIT_ACK) && (ACK_TIMEOUT != 0) &&
                        (r_cnt == 16'(ACK_TIMEOUT - 1)) && !w_pra_wr && !w_cb_edge;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 16'd1;
        if (!w_hs_on || w_mode_chg) begin
            w_state_nx = HS_IDLE;
            w_cnt_nx   = '0;
        end else if (w_pra_wr) begin
            // A PRA write restarts the count and beats a coincident CB edge.
            w_state_nx = (w_mode == CA_ILOCK) ? HS_WAIT_ACK : HS_PULSE;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                HS_PULSE: begin
                    if (r_cnt == 16'(PULSE_LEN - 1)) begin
                        w_state_nx = HS_IDLE;
                        w_cnt_nx   = '0;
                    end
                end
                HS_WAIT_ACK: begin
                    if (w_cb_edge || w_timeout) begin
                        w_state_nx = HS_IDLE;
                        w_cnt_nx   = '0;
                    end
                end
                default: begin
                    w_state_nx = HS_IDLE;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_ca = 1'b1;
        if (w_mc) begin
            case (w_mode)
                CA_LOW:   w_ca = 1'b0;
                CA_HIGH:  w_ca = 1'b1;
                CA_PULSE: w_ca = (r_state == HS_IDLE);
                default:  w_ca = (r_state == HS_IDLE);
            endcase
        end
    end

    assign w_ilr_set = {w_timeout, w_cb_edge, w_pc_edge[4:0] & {5{w_mc}}};
    assign w_ilr_clr = (w_rd && (rs == REG_IMR_ILR)) ? r_ilr : 7'd0;

    always_comb begin
        case (rs)
            REG_PRA:     w_rdata = 8'(w_pa_rd);
            REG_PRB:     w_rdata = 8'(w_pb_rd);
            REG_PRC:     w_rdata = 8'(w_pc_rd);
            REG_DDRA:    w_rdata = 8'(pa_oe);
            REG_DDRB:    w_rdata = 8'(pb_oe);
            REG_DDRC:    w_rdata = 8'(w_ddrc);
            REG_IMR_ILR: w_rdata = {1'b0, r_ilr};
            default:     w_rdata = {4'b0, r_cr};
        endcase
    end

    always_ff @(posedge clock) begin
        if (!_reset) begin
            r_cs_sync <= '0;
            r_cs_d    <= 1'b0;
            r_dout    <= '0;
            r_dout_oe <= 1'b0;
            r_imr     <= '0;
            r_ilr     <= '0;
            r_cr      <= '0;
            r_irq_n   <= 1'b1;
            r_pc_prev <= '0;
            r_state   <= HS_IDLE;
            r_cnt     <= '0;
        end else begin
            r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_cs_d    <= w_cs_s;
            r_pc_prev <= w_pc_s8;
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_ilr     <= (r_ilr & ~w_ilr_clr) | w_ilr_set;
            r_irq_n   <= !(w_mc && |(r_ilr & r_imr));
            if (w_wr && (rs == REG_IMR_ILR)) r_imr <= din[6:0];
            if (w_cr_wr) r_cr <= {din[3:1], din[CR_MC] && (PC_W == 8)};
            if (w_rd) begin
                r_dout    <= w_rdata;
                r_dout_oe <= 1'b1;
            end else if (w_cs_s) begin
                r_dout    <= '0;
                r_dout_oe <= 1'b0;
            end
        end
    end

    assign dout    = r_dout;
    assign dout_oe = r_dout_oe;
    assign irq_n   = r_irq_n;

    generate
        if (PC_W == 8) begin : g_mc
            always_comb begin
                pc_o  = w_prc;
                pc_oe = w_ddrc;
                if (w_mc) begin
                    pc_o[6]    = w_ca;
                    pc_o[5]    = r_irq_n;
                    pc_oe[7:5] = 3'b011;
                end else if (!w_ddrc[6]) begin
                    // An undriven pc6 presents CA's idle level.
                    pc_o[6] = w_ca;
                end
            end
        end else begin : g_plain
            assign pc_o  = w_prc;
            assign pc_oe = w_ddrc;
            logic w_ca_unused;
            assign w_ca_unused = w_ca;
        end
    endgenerate

endmodule

// File: tb/tb_tpi_sync.sv
// Directed bench for tpi_sync: port access, interrupts, CA pulse/interlock handshake and reset.
module tb_tpi_sync;
    import tpi_pkg::*;

    logic       clock;
    logic       _reset;
    logic       cs_n, we_n;
    logic [2:0] rs;
    logic [7:0] din, dout;
    logic       dout_oe, irq_n;
    logic [7:0] pa_i, pa_o, pa_oe;
    logic [1:0] pb_i, pb_o, pb_oe;
    logic [7:0] pc_i, pc_o, pc_oe;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         ca_low  = 0;
    logic [7:0] rd;

    tpi_sync #(
        .PA_W(8), .PB_W(2), .PC_W(8), .SYNC_STAGES(2), .PULSE_LEN(4), .ACK_TIMEOUT(16)
    ) dut (
        .clock(clock), ._reset(_reset), .cs_n(cs_n), .we_n(we_n), .rs(rs), .din(din),
        .dout(dout), .dout_oe(dout_oe),
        .pa_i(pa_i), .pa_o(pa_o), .pa_oe(pa_oe),
        .pb_i(pb_i), .pb_o(pb_o), .pb_oe(pb_oe),
        .pc_i(pc_i), .pc_o(pc_o), .pc_oe(pc_oe),
        .irq_n(irq_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; samples settle 1ns after the edge. Counts cycles with CA low.
    task automatic tick();
        @(posedge clock);
        #1;
        if (pc_o[6] == 1'b0) ca_low++;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        we_n = 1'b0; rs = a; din = d; cs_n = 1'b0;
        repeat (3) tick();
        cs_n = 1'b1;
        repeat (3) tick();
        we_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        we_n = 1'b1; rs = a; cs_n = 1'b0;
        repeat (2) tick();
        check("rd_oe_early", 16'(dout_oe), 16'h0);
        tick();
        check("rd_oe_valid", 16'(dout_oe), 16'h1);
        d = dout;
        cs_n = 1'b1;
        repeat (3) tick();
        check("rd_oe_release", 16'(dout_oe), 16'h0);
    endtask

    initial begin
        _reset = 1'b0; cs_n = 1'b1; we_n = 1'b1; rs = '0; din = '0;
        pa_i = 8'h3C; pb_i = 2'b00; pc_i = 8'h81;
        repeat (3) tick();
        check("rst_irq_n",   16'(irq_n),   16'h1);
        check("rst_pc_o",    16'(pc_o),    16'h0040);
        check("rst_pc_oe",   16'(pc_oe),   16'h0);
        check("rst_pa_oe",   16'(pa_oe),   16'h0);
        check("rst_dout_oe", 16'(dout_oe), 16'h0);
        _reset = 1'b1;
        repeat (4) tick();

        // Port A readback mixes PR and pins through DDR
        bus_write(REG_DDRA, 8'hF0);
        bus_write(REG_PRA, 8'hA5);
        check("pa_oe", 16'(pa_oe), 16'h00F0);
        check("pa_o",  16'(pa_o),  16'h00A5);
        bus_read(REG_PRA, rd);
        check("pra_read", 16'(rd), 16'h00AC);

        // Narrow port B: upper bits dropped and read as 0
        bus_write(REG_PRB, 8'hFF);
        bus_write(REG_DDRB, 8'hFF);
        check("pb_o", 16'(pb_o), 16'h0003);
        bus_read(REG_PRB, rd);
        check("prb_read", 16'(rd), 16'h0003);

        // Falling edge on pc0 latches ILR0 and drives irq_n low
        bus_write(REG_IMR_ILR, 8'h01);
        bus_write(REG_CR, 8'h01);
        check("mc_pc_oe", 16'(pc_oe), 16'h0060);
        pc_i = 8'h80;
        for (int k = 0; k < 4 && irq_n == 1'b1; k++) tick();
        check("irq_assert", 16'(irq_n), 16'h0);
        bus_read(REG_IMR_ILR, rd);
        check("ilr_pc0", 16'(rd), 16'h0001);
        check("irq_clear", 16'(irq_n), 16'h1);
        bus_read(REG_IMR_ILR, rd);
        check("ilr_empty", 16'(rd), 16'h0);

        // Pulse mode: 4 low cycles, then restart two cycles in gives 6
        bus_write(REG_CR, 8'h09);
        ca_low = 0;
        bus_write(REG_PRA, 8'h11);
        repeat (6) tick();
        check("pulse_len", 16'(ca_low), 16'd4);
        check("pulse_idle", 16'(pc_o[6]), 16'h1);
        ca_low = 0;
        we_n = 1'b0; rs = REG_PRA; din = 8'h22;
        cs_n = 1'b0; tick();
        cs_n = 1'b1; tick();
        cs_n = 1'b0; tick();
        cs_n = 1'b1;
        repeat (12) tick();
        we_n = 1'b1;
        check("pulse_restart", 16'(ca_low), 16'd6);

        // Interlocked: CB falling edge acknowledges
        bus_write(REG_CR, 8'h0D);
        ca_low = 0;
        bus_write(REG_PRA, 8'h33);
        tick();
        pc_i = 8'h00;
        repeat (10) tick();
        check("ack_cb_low", 16'(ca_low), 16'd7);
        bus_read(REG_IMR_ILR, rd);
        check("ilr_cb", 16'(rd), 16'h0020);

        // Interlocked: no acknowledge, timeout after 16 cycles
        ca_low = 0;
        bus_write(REG_PRA, 8'h44);
        repeat (20) tick();
        check("ack_timeout_low", 16'(ca_low), 16'd16);
        bus_read(REG_IMR_ILR, rd);
        check("ilr_timeout", 16'(rd), 16'h0040);

        // CB edge coincident with a PRA write: the write wins
        pc_i = 8'h80;
        repeat (4) tick();
        bus_write(REG_IMR_ILR, 8'h21);
        we_n = 1'b0; rs = REG_PRA; din = 8'h55; cs_n = 1'b0; pc_i = 8'h00;
        repeat (3) tick();
        cs_n = 1'b1;
        repeat (3) tick();
        we_n = 1'b1;
        check("race_ca_low", 16'(pc_o[6]), 16'h0);
        check("race_irq",    16'(irq_n),   16'h0);
        check("race_pa_o",   16'(pa_o),    16'h0055);

        // Reset in WAIT_ACK with a read in progress
        rs = REG_DDRA; cs_n = 1'b0;
        repeat (3) tick();
        check("pre_rst_oe",   16'(dout_oe), 16'h1);
        check("pre_rst_dout", 16'(dout),    16'h00F0);
        check("pre_rst_ca",   16'(pc_o[6]), 16'h0);
        _reset = 1'b0;
        tick();
        check("rst2_ca",      16'(pc_o[6]), 16'h1);
        check("rst2_dout_oe", 16'(dout_oe), 16'h0);
        check("rst2_dout",    16'(dout),    16'h0);
        check("rst2_irq_n",   16'(irq_n),   16'h1);
        check("rst2_pa_o",    16'(pa_o),    16'h0);
        check("rst2_pa_oe",   16'(pa_oe),   16'h0);
        check("rst2_pc_oe",   16'(pc_oe),   16'h0);
        _reset = 1'b1;
        repeat (4) tick();
        check("rst2_no_access", 16'(dout_oe), 16'h0);
        cs_n = 1'b1;
        repeat (4) tick();
        bus_read(REG_DDRA, rd);
        check("rst2_ddra", 16'(rd), 16'h0);
        bus_read(REG_CR, rd);
        check("rst2_cr", 16'(rd), 16'h0);
        bus_read(REG_IMR_ILR, rd);
        check("rst2_ilr", 16'(rd), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
